// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// Module  : muldiv_pkg
// Brief   : Shared constants and encodings for the iterative RV32M/RV64M unit.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
//------------------------------------------------------------------------------
// Module  : muldiv_step
// Brief   : One combinational shift-add (multiply) or restoring
//           shift-subtract (divide) step on a 2*XLEN accumulator.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_trial;
    logic [XLEN:0] w_diff;

    always_comb begin
        // Multiply: {hi, multiplier}; the carry out of hi shifts into the top.
        w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, (i_acc[0] ? i_opnd : '0)};
        // Divide: {rem, quo}; the trial value is rem shifted left with the next dividend bit.
        w_trial = i_acc[2*XLEN-1:XLEN-1];
        w_diff  = w_trial - {1'b0, i_opnd};
        o_acc   = {w_sum, i_acc[XLEN-1:1]};
        if (i_is_div) begin
            if (!w_diff[XLEN]) begin
                o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            end else begin
                o_acc = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// Module  : muldiv_unit
// Brief   : Iterative one-bit-per-cycle multiply/divide unit with valid/ready
//           request and result handshakes.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero,
    output logic            illegal
);

    localparam int              c_cnt_w    = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(XLEN - 1);
    localparam logic [XLEN-1:0] c_most_neg = {1'b1, {(XLEN-1){1'b0}}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    funct3_t             r_f3;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_result;
    logic                r_dbz;
    logic                r_illegal;

    funct3_t             w_f3;
    logic                w_is_div;
    logic                w_signed_a;
    logic                w_signed_b;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_illegal;
    logic                w_dbz;
    logic                w_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_result;
    logic                w_accept;
    logic [2*XLEN-1:0]   w_acc_step;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_result;

    assign in_ready    = (r_state == IDLE) && !kill;
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = (r_state == DONE);
    assign result      = r_result;
    assign div_by_zero = r_dbz;
    assign illegal     = r_illegal;

    // Request decode, operand magnitudes and the single-edge special cases.
    always_comb begin
        w_f3       = funct3_t'(Funct3);
        w_is_div   = Funct3[2];
        w_signed_a = !(w_f3 inside {F3_MULHU, F3_DIVU, F3_REMU});
        w_signed_b = w_f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
        w_sign_a   = w_signed_a && op_a[XLEN-1];
        w_sign_b   = w_signed_b && op_b[XLEN-1];
        w_mag_a    = w_sign_a ? -op_a : op_a;
        w_mag_b    = w_sign_b ? -op_b : op_b;
        w_illegal  = (Funct7 != FUNCT7_MULDIV);
        w_dbz      = !w_illegal && w_is_div && (op_b == '0);
        w_ovf      = !w_illegal && (w_f3 inside {F3_DIV, F3_REM})
                     && (op_a == c_most_neg) && (op_b == '1);
        w_fast     = w_illegal || w_dbz || w_ovf;
        w_fast_result = '0;
        if (w_dbz) begin
            w_fast_result = Funct3[1] ? op_a : '1;
        end else if (w_ovf) begin
            w_fast_result = Funct3[1] ? '0 : op_a;
        end
    end

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_is_div (r_f3[2]),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_acc_step)
    );

    // Sign fix-up and result selection once all XLEN steps are done.
    always_comb begin
        w_prod       = r_neg_q ? -r_acc : r_acc;
        w_quo        = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem        = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        w_fix_result = w_rem;
        case (r_f3)
            F3_MUL:                       w_fix_result = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              w_fix_result = w_quo;
            default:                      w_fix_result = w_rem;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (kill) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (in_valid) w_state_nxt = w_fast ? DONE : CALC;
                CALC:    if (r_cnt == c_cnt_last) w_state_nxt = FIX;
                FIX:     w_state_nxt = DONE;
                DONE:    if (out_ready) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_f3      <= F3_MUL;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_dbz     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_f3    <= w_f3;
                        r_neg_q <= w_sign_a ^ w_sign_b;
                        r_neg_r <= w_sign_a;
                        r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                        r_opnd  <= w_mag_b;
                        r_cnt   <= '0;
                        if (w_fast) begin
                            r_result  <= w_fast_result;
                            r_dbz     <= w_dbz;
                            r_illegal <= w_illegal;
                        end
                    end
                end
                CALC: begin
                    if (!kill) begin
                        r_acc <= w_acc_step;
                        // Hold at the last count so the counter never wraps.
                        if (r_cnt != c_cnt_last) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                FIX: begin
                    if (!kill) begin
                        r_result  <= w_fix_result;
                        r_dbz     <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_muldiv_unit
// Brief   : Directed self-checking bench for muldiv_unit (XLEN = 32).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            div_by_zero;
    logic            illegal;

    int n_cmp;
    int n_err;

    muldiv_unit #(
        .XLEN (XLEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Funct7      (Funct7),
        .Funct3      (Funct3),
        .op_a        (op_a),
        .op_b        (op_b),
        .kill        (kill),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Latency counts edges after the accepting edge; fast paths land in DONE
    // on the accepting edge itself, so they report 0.
    task automatic run_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat,
                          input logic exp_dbz, input logic exp_ill);
        int lat;
        @(negedge clk);
        Funct7   = f7;
        Funct3   = f3;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".res"}, 64'(result), 64'(exp_res));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        check({tag, ".ill"}, 64'(illegal), 64'(exp_ill));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, ".retire"}, 64'({out_valid, in_ready}), 64'(2'b01));
        end
    endtask

    initial begin
        int rises;
        logic [31:0] held;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        Funct7    = 7'b0000001;
        Funct3    = 3'b000;
        op_a      = '0;
        op_b      = '0;
        kill      = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.result", 64'(result), 64'(0));
        check("rst.dbz", 64'(div_by_zero), 64'(0));
        check("rst.ill", 64'(illegal), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.in_ready", 64'(in_ready), 64'(1));

        run_op("mul",    7'h01, 3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0, 1'b0);
        run_op("mulh",   7'h01, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0, 1'b0);
        run_op("mulhu",  7'h01, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0, 1'b0);
        run_op("mulhsu", 7'h01, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0, 1'b0);
        run_op("div",    7'h01, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, 1'b0, 1'b0);
        run_op("rem",    7'h01, 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, 1'b0, 1'b0);
        run_op("divu",   7'h01, 3'b101, 32'd100,      32'd7,        32'd14,       33, 1'b0, 1'b0);
        run_op("remu",   7'h01, 3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b0, 1'b0);
        run_op("divu0",  7'h01, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0,  1'b1, 1'b0);
        run_op("remu0",  7'h01, 3'b111, 32'd5,        32'd0,        32'h00000005, 0,  1'b1, 1'b0);
        run_op("divovf", 7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,  1'b0, 1'b0);
        run_op("removf", 7'h01, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0,  1'b0, 1'b0);
        run_op("illeg",  7'h20, 3'b000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0,  1'b0, 1'b1);
        // A normal op after the flagged fast paths must clear both flags.
        run_op("mulclr", 7'h01, 3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 33, 1'b0, 1'b0);

        // Consumer back-pressure: result held, no new request accepted.
        out_ready = 1'b0;
        run_op("stall",  7'h01, 3'b101, 32'd1000,     32'd3,        32'd333,      33, 1'b0, 1'b0);
        held = result;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall.valid", 64'(out_valid), 64'(1));
            check("stall.hold", 64'(result), 64'(held));
            check("stall.in_ready", 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall.retire", 64'({out_valid, in_ready}), 64'(2'b01));

        // Abort on the tenth CALC edge.
        @(negedge clk);
        Funct7   = 7'h01;
        Funct3   = 3'b000;
        op_a     = 32'd5;
        op_b     = 32'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        #1;
        check("kill.idle", 64'({out_valid, in_ready}), 64'(2'b01));
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        check("kill.no_valid", 64'(rises), 64'(0));

        // Kill beats a simultaneous request in IDLE.
        @(negedge clk);
        Funct3   = 3'b101;
        op_a     = 32'd9;
        op_b     = 32'd0;
        in_valid = 1'b1;
        kill     = 1'b1;
        #1;
        check("killreq.in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        check("killreq.no_valid", 64'(rises), 64'(0));

        // Reset in the middle of CALC after a flagged result.
        run_op("prerst", 7'h01, 3'b111, 32'd5, 32'd0, 32'h00000005, 0, 1'b1, 1'b0);
        @(negedge clk);
        Funct7   = 7'h01;
        Funct3   = 3'b101;
        op_a     = 32'd100;
        op_b     = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst.out_valid", 64'(out_valid), 64'(0));
        check("midrst.result", 64'(result), 64'(0));
        check("midrst.dbz", 64'(div_by_zero), 64'(0));
        check("midrst.ill", 64'(illegal), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst.in_ready", 64'(in_ready), 64'(1));
        run_op("mul3x4", 7'h01, 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
